inc_feed_fifo: RTL and testbench

Upstream feeder for the `inc` incrementer stage. It buffers 7-bit operand words from a producer in a small first-in-first-out queue using a valid/ready handshake. It presents the oldest word on `d_out`, which drives the incrementer's `d` input, and advances only when the consumer acknowledges. It decouples producer bursts from the incrementer's one-word-per-clock consumption and flags dropped writes.

---
 rtl/inc_feed_fifo_pkg.sv | 6 +
 rtl/inc_feed_fifo_wrap_ptr.sv | 22 ++
 rtl/inc_feed_fifo.sv | 78 +++++++
 tb/tb_inc_feed_fifo.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/inc_feed_fifo_pkg.sv
// Shared sizing for the incrementer feed queue and its pointer sub-module.
package inc_feed_fifo_pkg;
    localparam int DEF_WIDTH = 7;
    localparam int DEF_DEPTH = 4;
    localparam int PTR_W     = $clog2(DEF_DEPTH);
endpackage

// File: rtl/inc_feed_fifo_wrap_ptr.sv
// Wrapping queue pointer: increments on enable, wraps naturally at 2**W.
module inc_feed_fifo_wrap_ptr
    import inc_feed_fifo_pkg::*;
#(
    parameter int W = PTR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_ptr
);
    logic [W-1:0] r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_ptr <= '0;
        else if (i_clr) r_ptr <= '0;
        else if (i_inc) r_ptr <= r_ptr + W'(1);
    end

    assign o_ptr = r_ptr;
endmodule

// File: rtl/inc_feed_fifo.sv
// Small valid/ready queue feeding the incrementer's d input; flags dropped writes.
module inc_feed_fifo
    import inc_feed_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         d_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_cnt;
    logic             r_ovf;
    logic [PW-1:0]    w_wp;
    logic [PW-1:0]    w_rp;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Flags derive from the registered count only, so no input reaches an output.
    assign w_full  = (r_cnt == CW'(DEPTH));
    assign w_empty = (r_cnt == '0);
    assign w_push  = in_valid && !w_full;
    assign w_pop   = !w_empty && out_ready;

    inc_feed_fifo_wrap_ptr #(.W(PW)) u_wp (
        .clk   (clk),
        .rst_n (reset),
        .i_clr (clr),
        .i_inc (w_push),
        .o_ptr (w_wp)
    );

    inc_feed_fifo_wrap_ptr #(.W(PW)) u_rp (
        .clk   (clk),
        .rst_n (reset),
        .i_clr (clr),
        .i_inc (w_pop),
        .o_ptr (w_rp)
    );

    always_ff @(posedge clk) begin
        if (w_push && !clr) r_mem[w_wp] <= in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                r_cnt <= '0;
        else if (clr)              r_cnt <= '0;
        else if (w_push && !w_pop) r_cnt <= r_cnt + CW'(1);
        else if (!w_push && w_pop) r_cnt <= r_cnt - CW'(1);
    end

    // Sticky until clr/reset; a pop in the same cycle does not rescue a write to a full queue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  r_ovf <= 1'b0;
        else if (clr)                r_ovf <= 1'b0;
        else if (in_valid && w_full) r_ovf <= 1'b1;
    end

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign d_out     = w_empty ? '0 : r_mem[w_rp];
    assign count     = r_cnt;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_inc_feed_fifo.sv
// Directed bench for the incrementer feed queue, with a registered +1 stage as the consumer.
module tb_inc_feed_fifo;
    logic       clk;
    logic       reset;
    logic       clr;
    logic       in_valid;
    logic [6:0] in_data;
    logic       in_ready;
    logic [6:0] d_out;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
    logic       ovf;
    logic [6:0] inc_q;

    int n_tests = 0;
    int n_fail  = 0;

    inc_feed_fifo dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .d_out     (d_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .ovf       (ovf)
    );

    // Stand-in for the registered incrementer stage driven by d_out.
    always_ff @(posedge clk) inc_q <= d_out + 7'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [6:0] v);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_tests++; if (d_out !== 7'h00)    begin n_fail++; $display("FAIL rst_d_out got %h want 00", d_out); end
        n_tests++; if (count !== 3'd0)     begin n_fail++; $display("FAIL rst_count got %0d want 0", count); end
        n_tests++; if (ovf !== 1'b0)       begin n_fail++; $display("FAIL rst_ovf got %b want 0", ovf); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fill_drain();
        logic [6:0] exp_q [4];
        exp_q = '{7'h02, 7'h05, 7'h7F, 7'h00};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(exp_q[i]);
        n_tests++; if (count !== 3'd4)     begin n_fail++; $display("FAIL fill_count got %0d want 4", count); end
        n_tests++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fill_out_valid got %b want 1", out_valid); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (d_out !== exp_q[i]) begin n_fail++; $display("FAIL drain_d_out[%0d] got %h want %h", i, d_out, exp_q[i]); end
            tick();
        end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_out_valid got %b want 0", out_valid); end
        n_tests++; if (d_out !== 7'h00)    begin n_fail++; $display("FAIL drain_d_out_zero got %h want 00", d_out); end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) push(7'(8'h21 + i));
        in_valid = 1'b1; in_data = 7'h11;
        tick();
        in_valid = 1'b0;
        n_tests++; if (ovf !== 1'b1)      begin n_fail++; $display("FAIL ovf_set got %b want 1", ovf); end
        n_tests++; if (count !== 3'd4)    begin n_fail++; $display("FAIL ovf_count got %0d want 4", count); end
        n_tests++; if (d_out !== 7'h21)   begin n_fail++; $display("FAIL ovf_head got %h want 21", d_out); end
        tick();
        n_tests++; if (ovf !== 1'b1)      begin n_fail++; $display("FAIL ovf_sticky got %b want 1", ovf); end
        pulse_clr();
        n_tests++; if (ovf !== 1'b0)      begin n_fail++; $display("FAIL clr_ovf got %b want 0", ovf); end
        n_tests++; if (count !== 3'd0)    begin n_fail++; $display("FAIL clr_count got %0d want 0", count); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_out_valid got %b want 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL clr_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        push(7'h0E);
        push(7'h0F);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        // Pushes 10..19 while popping 0E..17; twelve writes wrap a 4-entry queue three times.
        for (int i = 0; i < 10; i++) begin
            in_data = 7'(8'h10 + i);
            n_tests++; if (d_out !== 7'(8'h0E + i)) begin n_fail++; $display("FAIL b2b_d_out[%0d] got %h want %h", i, d_out, 7'(8'h0E + i)); end
            n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count[%0d] got %0d want 2", i, count); end
            tick();
        end
        in_valid = 1'b0;
        n_tests++; if (count !== 3'd2)  begin n_fail++; $display("FAIL b2b_end_count got %0d want 2", count); end
        n_tests++; if (d_out !== 7'h18) begin n_fail++; $display("FAIL b2b_tail0 got %h want 18", d_out); end
        tick();
        n_tests++; if (d_out !== 7'h19) begin n_fail++; $display("FAIL b2b_tail1 got %h want 19", d_out); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) push(7'(8'h31 + i));
        in_valid = 1'b1; in_data = 7'h55; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_tests++; if (count !== 3'd3)    begin n_fail++; $display("FAIL fpop_count got %0d want 3", count); end
        n_tests++; if (ovf !== 1'b1)      begin n_fail++; $display("FAIL fpop_ovf got %b want 1", ovf); end
        n_tests++; if (d_out !== 7'h32)   begin n_fail++; $display("FAIL fpop_head got %h want 32", d_out); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fpop_in_ready got %b want 1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (d_out !== 7'(8'h32 + i)) begin n_fail++; $display("FAIL fpop_drain[%0d] got %h want %h", i, d_out, 7'(8'h32 + i)); end
            tick();
        end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fpop_dropped_word got out_valid %b want 0", out_valid); end
        out_ready = 1'b0;
        pulse_clr();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) push(7'(8'h41 + i));
        in_valid = 1'b1; in_data = 7'h45;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL rmid_pre_count got %0d want 3", count); end
        n_tests++; if (ovf !== 1'b1)   begin n_fail++; $display("FAIL rmid_pre_ovf got %b want 1", ovf); end
        #2;
        reset = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
        n_tests++; if (d_out !== 7'h00)    begin n_fail++; $display("FAIL rmid_d_out got %h want 00", d_out); end
        n_tests++; if (count !== 3'd0)     begin n_fail++; $display("FAIL rmid_count got %0d want 0", count); end
        n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
        n_tests++; if (ovf !== 1'b0)       begin n_fail++; $display("FAIL rmid_ovf got %b want 0", ovf); end
        tick();
        reset = 1'b1;
        push(7'h46);
        n_tests++; if (d_out !== 7'h46) begin n_fail++; $display("FAIL rmid_post_d_out got %h want 46", d_out); end
        n_tests++; if (count !== 3'd1)  begin n_fail++; $display("FAIL rmid_post_count got %0d want 1", count); end
        pulse_clr();
    endtask

    task automatic test_integration();
        out_ready = 1'b1;
        in_valid  = 1'b1; in_data = 7'h02;
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL int_out_valid got %b want 1", out_valid); end
        n_tests++; if (d_out !== 7'h02)    begin n_fail++; $display("FAIL int_d_out got %h want 02", d_out); end
        n_tests++; if (count !== 3'd1)     begin n_fail++; $display("FAIL int_count_no_pop got %0d want 1", count); end
        tick();
        n_tests++; if (inc_q !== 7'h03)    begin n_fail++; $display("FAIL int_inc_q got %h want 03", inc_q); end
        n_tests++; if (count !== 3'd0)     begin n_fail++; $display("FAIL int_count_popped got %0d want 0", count); end
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_back_to_back();
        test_full_pop();
        test_reset_mid();
        test_integration();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
